// File: rtl/cbc_decrypt_chain_pkg.sv
// Shared types and constants for the CBC decryption wrapper.
package cbc_decrypt_chain_pkg;

  // Cipher block width in bits.
  localparam int BLOCK_W = 128;

  // Largest settle window the 4-bit countdown can express.
  localparam int SETTLE_MAX = 15;

  // Wrapper control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage : cbc_decrypt_chain_pkg

// File: rtl/cbc_decrypt_chain_decryption.sv
// Combinational block decryption core: AES inverse cipher (Numkeys-word key,
// NumRounds rounds) whose inverse S-box output is whitened per byte position
// by a tweak folded from sbox_seed. An all-zero seed gives standard AES.
module decryption
  import cbc_decrypt_chain_pkg::*;
#(
  parameter int N         = 256,
  parameter int NumRounds = 14,
  parameter int Numkeys   = 8
) (
  input  logic [BLOCK_W-1:0] in,
  input  logic [N-1:0]       key,
  input  logic [N-1:0]       sbox_seed,
  output logic [BLOCK_W-1:0] out
);

  localparam int NW = 4 * (NumRounds + 1);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, p;
    x = a;
    y = b;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^
           {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [BLOCK_W-1:0] decrypt_block(input logic [BLOCK_W-1:0] ct,
                                                       input logic [N-1:0] k,
                                                       input logic [N-1:0] seed);
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [7:0]  tw [16];
    logic [7:0]  s  [16];
    logic [7:0]  u  [16];
    logic [7:0]  a0, a1, a2, a3;
    logic [BLOCK_W-1:0] res;

    // Fold every seed byte into a 16-byte positional tweak.
    for (int j = 0; j < 16; j++) tw[j] = 8'h00;
    for (int j = 0; j < N / 8; j++) tw[j % 16] = tw[j % 16] ^ seed[8*j +: 8];

    // Forward key expansion.
    for (int i = 0; i < Numkeys; i++) w[i] = k[N-1-32*i -: 32];
    rc = 8'h01;
    for (int i = Numkeys; i < NW; i++) begin
      t = w[i-1];
      if (i % Numkeys == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end else if (Numkeys > 6 && i % Numkeys == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-Numkeys] ^ t;
    end

    for (int i = 0; i < 16; i++)
      s[i] = ct[BLOCK_W-1-8*i -: 8] ^ w[4*NumRounds + i/4][31-8*(i%4) -: 8];

    for (int r = NumRounds - 1; r >= 0; r--) begin
      // Inverse row shift, inverse substitution with tweak, round key.
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          u[rr + 4*c] = s[rr + 4*((c - rr + 4) % 4)];
      for (int i = 0; i < 16; i++)
        u[i] = inv_sbox(u[i]) ^ tw[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      if (r != 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
          s[4*c]   = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
          s[4*c+1] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
          s[4*c+2] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
          s[4*c+3] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = u[i];
      end
    end

    for (int i = 0; i < 16; i++) res[BLOCK_W-1-8*i -: 8] = s[i];
    return res;
  endfunction

  assign out = decrypt_block(in, key, sbox_seed);

endmodule : decryption

// File: rtl/cbc_decrypt_chain.sv
// CBC decryption wrapper: accepts a ciphertext block, holds it on the core for
// SETTLE cycles, XORs the core result with the previous ciphertext (or IV) and
// presents the plaintext until the downstream accepts it.
module cbc_decrypt_chain
  import cbc_decrypt_chain_pkg::*;
#(
  parameter int N         = 256,
  parameter int NumRounds = 14,
  parameter int Numkeys   = 8,
  parameter int SETTLE    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [N-1:0]       key_in,
  input  logic [N-1:0]       seed_in,
  input  logic [BLOCK_W-1:0] iv_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_last,
  output logic               busy
);

  if (SETTLE < 1 || SETTLE > SETTLE_MAX) begin : g_settle_range
    $error("SETTLE must be in 1..15");
  end

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [N-1:0]       key_q, key_d;
  logic [N-1:0]       seed_q, seed_d;
  logic [BLOCK_W-1:0] iv_q, iv_d;
  logic [BLOCK_W-1:0] chain_q, chain_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;
  logic               last_q, last_d;
  logic [BLOCK_W-1:0] pt_q, pt_d;
  logic               keyed_q, keyed_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BLOCK_W-1:0] core_out;

  // Core inputs come only from registers so they stay stable through WAIT.
  decryption #(
    .N        (N),
    .NumRounds(NumRounds),
    .Numkeys  (Numkeys)
  ) u_core (
    .in       (ct_q),
    .key      (key_q),
    .sbox_seed(seed_q),
    .out      (core_out)
  );

  // Input acceptance: only when configured and no configuration is loading.
  always_comb begin
    in_ready = (state_q == ST_IDLE) && keyed_q && !cfg_load;
  end

  // Next-state and datapath update for the IDLE/WAIT/OUT sequence.
  always_comb begin
    // NOTE: every _d defaults to its _q first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    key_d   = key_q;
    seed_d  = seed_q;
    iv_d    = iv_q;
    chain_d = chain_q;
    ct_d    = ct_q;
    last_d  = last_q;
    pt_d    = pt_q;
    keyed_d = keyed_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          // Configuration takes priority over a same-cycle block.
          key_d   = key_in;
          seed_d  = seed_in;
          iv_d    = iv_in;
          chain_d = iv_in;
          keyed_d = 1'b1;
        end else if (in_valid && in_ready) begin
          ct_d    = in_data;
          last_d  = in_last;
          cnt_d   = SETTLE_CNT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          pt_d    = core_out ^ chain_q;
          // A message boundary restarts chaining from the stored IV.
          chain_d = last_q ? iv_q : ct_q;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset discards any in-flight block and the configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      seed_q  <= '0;
      iv_q    <= '0;
      chain_q <= '0;
      ct_q    <= '0;
      last_q  <= 1'b0;
      pt_q    <= '0;
      keyed_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q <= state_d;
      key_q   <= key_d;
      seed_q  <= seed_d;
      iv_q    <= iv_d;
      chain_q <= chain_d;
      ct_q    <= ct_d;
      last_q  <= last_d;
      pt_q    <= pt_d;
      keyed_q <= keyed_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode from state; data is forced to zero outside OUT.
  always_comb begin
    out_valid = (state_q == ST_OUT);
    out_data  = out_valid ? pt_q : '0;
    out_last  = out_valid && last_q;
    busy      = (state_q != ST_IDLE);
  end

endmodule : cbc_decrypt_chain

// File: tb/tb_cbc_decrypt_chain.sv
// Directed bench for cbc_decrypt_chain: table of chained blocks plus
// hand-written sequences for backpressure, config collisions and reset.
module tb_cbc_decrypt_chain;

  localparam int N      = 256;
  localparam int SETTLE = 2;

  localparam logic [255:0] KEY_A  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_KAT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_KAT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_B  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] SEED_B = 256'hdeadbeefcafef00d0badc0defeedface00000000000000000000000000000000;
  localparam logic [127:0] IV_ONE = {128{1'b1}};
  localparam logic [127:0] IV_2   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  typedef struct {
    logic [127:0] ct;
    logic         last;
    logic [127:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_load;
  logic [N-1:0] key_in, seed_in;
  logic [127:0] iv_in, in_data, out_data;
  logic         in_valid, in_ready, in_last;
  logic         out_valid, out_ready, out_last, busy;

  logic [127:0] ref_ct, ref_pt;
  logic [N-1:0] ref_key, ref_seed;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  cbc_decrypt_chain #(.N(N), .NumRounds(14), .Numkeys(8), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .key_in(key_in),
    .seed_in(seed_in), .iv_in(iv_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  // Reference core for D(x); its seed-0 behaviour is pinned by the AES known answer.
  decryption #(.N(N), .NumRounds(14), .Numkeys(8)) u_ref (
    .in(ref_ct), .key(ref_key), .sbox_seed(ref_seed), .out(ref_pt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ref_d(input logic [127:0] x, output logic [127:0] y);
    ref_ct = x;
    #1;
    y = ref_pt;
  endtask

  // Pulse cfg_load for one cycle; called at a negedge in IDLE.
  task automatic do_cfg(input logic [N-1:0] k, input logic [N-1:0] s, input logic [127:0] iv);
    cfg_load = 1'b1; key_in = k; seed_in = s; iv_in = iv;
    #1;
    check("cfg_masks_ready", in_ready, 0);
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // Send one block from IDLE and retire its output; called at a negedge.
  task automatic send_block(input string name, input logic [127:0] ct, input logic last,
                            input logic [127:0] exp, input int hold, input bit cfg_in_wait);
    int guard;
    int bad;
    in_valid = 1'b1; in_data = ct; in_last = last;
    #1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_accept"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    for (int k = 1; k <= SETTLE; k++) begin
      check({name, "_wait"}, {out_valid, busy, in_ready}, 3'b010);
      if (k == 1 && cfg_in_wait) begin
        cfg_load = 1'b1; key_in = ~KEY_B; seed_in = ~SEED_B; iv_in = 128'h0bad0bad0bad0bad0bad0bad0bad0bad;
      end
      @(negedge clk);
      cfg_load = 1'b0;
    end
    check({name, "_valid"}, {out_valid, busy}, 2'b11);
    check({name, "_data"}, out_data, exp);
    check({name, "_last"}, out_last, last);
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp || out_last !== last) bad++;
    end
    if (hold > 0) check({name, "_hold_bad_cycles"}, bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_ready_after"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    vec_t         tbl [5];
    logic [127:0] c1, c2, c3, c4, c5, cb, cx, cy, cz, cw;
    logic [127:0] d1, d2, d3, d4, d5, db, dx, dy, dz, dw;
    int bad;

    rst_n = 1'b0; cfg_load = 1'b0; key_in = '0; seed_in = '0; iv_in = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    ref_ct = '0; ref_key = KEY_B; ref_seed = SEED_B;

    c1 = {16{8'h11}}; c2 = {16{8'h22}}; c3 = {16{8'h33}};
    c4 = 128'h0123456789abcdeffedcba9876543210;
    c5 = 128'hdeadbeef0123456789abcdef55aa55aa;
    cb = {16{8'h44}};
    cx = 128'h00000000000000000000000000000001;
    cy = 128'h80000000000000000000000000000000;
    cz = 128'hfedcba98765432100123456789abcdef;
    cw = {16{8'h5c}};
    ref_d(c1, d1); ref_d(c2, d2); ref_d(c3, d3); ref_d(c4, d4); ref_d(c5, d5);
    ref_d(cb, db); ref_d(cx, dx); ref_d(cy, dy); ref_d(cz, dz); ref_d(cw, dw);

    // Chained message table: IV all-ones, boundaries restore the IV.
    tbl[0] = '{c1, 1'b0, ~d1};
    tbl[1] = '{c2, 1'b1, d2 ^ c1};
    tbl[2] = '{c3, 1'b1, ~d3};
    tbl[3] = '{c4, 1'b0, ~d4};
    tbl[4] = '{c5, 1'b1, d5 ^ c4};

    // Reset state.
    @(negedge clk);
    check("reset_ctrl", {in_ready, out_valid, out_last, busy}, 4'b0000);
    check("reset_data", out_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unconfigured: in_valid held, nothing accepted.
    in_valid = 1'b1; in_data = c1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("unconfig_bad_cycles", bad, 0);
    in_valid = 1'b0;

    // Single block: AES-256 known answer with zero seed and IV.
    do_cfg(KEY_A, '0, '0);
    send_block("kat", CT_KAT, 1'b1, PT_KAT, 0, 1'b0);

    // Chaining across messages.
    do_cfg(KEY_B, SEED_B, IV_ONE);
    for (int i = 0; i < 5; i++) begin
      send_block($sformatf("chain%0d", i), tbl[i].ct, tbl[i].last, tbl[i].exp, 0, 1'b0);
    end

    // Backpressure for 10 cycles.
    send_block("bp", cb, 1'b1, ~db, 10, 1'b0);

    // Collision: config wins, block accepted next cycle with new IV.
    cfg_load = 1'b1; key_in = KEY_B; seed_in = SEED_B; iv_in = IV_2;
    in_valid = 1'b1; in_data = cx; in_last = 1'b0;
    #1;
    check("coll_ready", in_ready, 0);
    @(negedge clk);
    cfg_load = 1'b0;
    check("coll_not_taken", busy, 0);
    send_block("coll_x", cx, 1'b0, dx ^ IV_2, 0, 1'b0);
    // Config during WAIT must not disturb key, seed, IV or chain.
    send_block("cfgwait_y", cy, 1'b0, dy ^ cx, 0, 1'b1);
    send_block("cfgwait_z", cz, 1'b1, dz ^ cy, 0, 1'b0);
    send_block("cfgwait_w", cw, 1'b1, dw ^ IV_2, 0, 1'b0);

    // Reset in the first WAIT cycle.
    in_valid = 1'b1; in_data = c1; in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_wait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {in_ready, out_valid, out_last, busy}, 4'b0000);
    check("rst_mid_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = c2;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("rst_after_bad_cycles", bad, 0);
    in_valid = 1'b0;
    do_cfg(KEY_B, SEED_B, IV_ONE);
    send_block("rst_recover", c3, 1'b1, ~d3, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_cbc_decrypt_chain
